wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage that sits directly upstream of the integer register file and drives its single write port (rd_addr/rd_wdata/rd_wen).
- Merges two result sources:
  - single-cycle ALU results, which have priority;
  - load returns from the LSU, which are buffered in a small FIFO, sign/zero-extended at dequeue, and protected from starvation by a bounded-wait counter.
- Exports a pending-destination mask for hazard logic in decode.

Parameters:
LSU_FIFO_DEPTH, 4, number of buffered load returns (power of 2, >=2)
STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may lose arbitration before ALU is held off

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted when alu_valid&&alu_ready
alu_rd  in  5  ALU destination
alu_data  in  32  ALU result
lsu_valid  in  1  load return valid
lsu_ready  out  1  FIFO can accept (!full && !rst)
lsu_rd  in  5  load destination
lsu_data  in  32  raw aligned memory word
lsu_funct3  in  3  load type (RV32I encoding)
lsu_byte_off  in  2  address[1:0] of load
rd_addr  out  5  register-file write address
rd_wdata  out  32  register-file write data
rd_wen  out  1  register-file write enable
pend_mask  out  32  bit i set if any FIFO entry targets x[i], i!=0; bit0 always 0

Behaviour:
- Reset (async, active-high):
  - rd_wen=0, rd_addr=0, rd_wdata=0.
  - FIFO empty, pend_mask=0, starve counter=0.
  - lsu_ready=0 while rst is high; alu_ready=1.
- Enqueue: when lsu_valid&&lsu_ready, push {rd, data, funct3, byte_off}.
  - No same-cycle enqueue when full, even if a dequeue occurs that cycle.
- Arbitration each cycle, in priority order:
  1. alu_valid&&alu_ready: register the ALU result.
  2. Else if FIFO not empty: dequeue head and register the extended load result.
  3. Else: rd_wen=0 next cycle; rd_addr/rd_wdata hold their previous values.
- Latency:
  - ALU accepted at cycle N -> rd_wen=1 at N+1.
  - LSU enqueued at N -> earliest rd_wen at N+2. There is no FIFO bypass.
- Outputs rd_addr, rd_wdata, rd_wen are registered.
  - rd_wen is forced to 0 when the selected rd==0; the source is still consumed.
- Load extension, applied at dequeue:
  - LB (000): byte lsu_byte_off, sign-extended.
  - LH (001): halfword lsu_byte_off[1], sign-extended.
  - LW (010): full word.
  - LBU (100): byte, zero-extended.
  - LHU (101): halfword, zero-extended.
  - Any other code: treated as LW.
  - Misaligned LH/LW: lsu_byte_off[0] (and [1] for LW) ignored.
- Starvation:
  - starve_cnt increments on every cycle that the FIFO is non-empty and ALU wins.
  - When starve_cnt==STARVE_LIMIT: alu_ready=0 (combinational from the counter), FIFO head dequeues, counter clears.
  - Counter also clears on any FIFO dequeue or when the FIFO is empty.
  - starve_cnt saturates; it never wraps.
- FIFO pointers are log2(depth)+1 bits.
  - full when the MSBs differ and the rest are equal; empty when the pointers are equal.
  - Wrap-around is transparent.
- pend_mask: combinational OR of the one-hot rd of all valid entries.
- Reset mid-operation: all buffered loads are discarded, and any in-flight rd_wen is dropped immediately.

Optional Feature:
Macro WB_PERF_EN.
- Defined: adds outputs perf_wb_cnt (32) and perf_starve_cnt (32).
  - perf_wb_cnt counts cycles with rd_wen=1.
  - perf_starve_cnt counts cycles with alu_ready=0 && alu_valid=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package wb_pkg:
  - load funct3 localparams (LB, LH, LW, LBU, LHU);
  - packed struct lsu_entry_t {rd[4:0], data[31:0], funct3[2:0], byte_off[1:0]};
  - function load_extend(lsu_entry_t) -> logic [31:0].
- Sub-module wb_lsu_fifo: parameterised synchronous FIFO of lsu_entry_t with push/pop/full/empty and an entry-valid vector for pend_mask.
- Arbitration, starvation counter and output registers stay in wb_stage.

Test Plan:
1. Reset, then alu_valid=1, rd=5, data=0xDEADBEEF at cycle 1 -> cycle 2: rd_wen=1, rd_addr=5, rd_wdata=0xDEADBEEF; ALU with rd=0 -> rd_wen=0.
2. LSU LB, byte_off=2, data=0x0080FF00, rd=7, ALU idle -> 2 cycles later rd_wdata=0xFFFFFF80. LBU of the same entry -> 0x00000080. LH, byte_off=2 -> 0x00000080. LHU, byte_off=0 -> 0x0000FF00.
3. Push 4 loads (rd 1..4) while the ALU is continuously valid:
   - lsu_ready=0 after the 4th push;
   - pend_mask=0x0000001E;
   - after 3 ALU wins, alu_ready=0 for one cycle and rd_addr=1 is written next;
   - the remaining loads drain in the same pattern: each FIFO write is preceded by 3 ALU writes.
4. FIFO full with simultaneous dequeue and lsu_valid -> no enqueue that cycle; lsu_ready=1 the following cycle; pointer wrap over 10 push/pop pairs preserves order.
5. Assert rst mid-drain with 3 entries queued -> rd_wen=0 immediately, pend_mask=0, lsu_ready=0; after release the FIFO is empty and no stale writes occur.
6. With WB_PERF_EN: scenario 3 -> perf_starve_cnt=4; perf_wb_cnt equals the total number of ALU+LSU writes with rd!=0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the writeback stage.
//   - RV32I load funct3 codes (LB, LH, LW, LBU, LHU)
//   - lsu_entry_t: one buffered load return
//   - load_extend(): byte/halfword select and sign/zero extension
package wb_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  funct3;
    logic [1:0]  byte_off;
  } lsu_entry_t;

  // Unknown funct3 codes fall back to a full word. Halfword selection uses
  // only byte_off[1], so a misaligned halfword reads its aligned container.
  function automatic logic [31:0] load_extend(input lsu_entry_t e);
    logic [7:0]  b;
    logic [15:0] h;
    case (e.byte_off)
      2'd0:    b = e.data[7:0];
      2'd1:    b = e.data[15:8];
      2'd2:    b = e.data[23:16];
      default: b = e.data[31:24];
    endcase
    h = e.byte_off[1] ? e.data[31:16] : e.data[15:0];
    case (e.funct3)
      LB:      load_extend = {{24{b[7]}}, b};
      LH:      load_extend = {{16{h[15]}}, h};
      LBU:     load_extend = {24'd0, b};
      LHU:     load_extend = {16'd0, h};
      default: load_extend = e.data;
    endcase
  endfunction

endpackage

// File: rtl/wb_lsu_fifo.sv
// wb_lsu_fifo: synchronous FIFO of lsu_entry_t for buffered load returns.
// Ports:
//   clk, rst         clock, async active-high reset (pointers only)
//   push, din        enqueue (ignored when full)
//   pop, dout        dequeue (ignored when empty); dout is the head entry
//   full, empty      status
//   ent_vld, ent_rd  per-slot valid flag and destination, for hazard masks
module wb_lsu_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  lsu_entry_t             din,
  input  logic                   pop,
  output lsu_entry_t             dout,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH-1:0]       ent_vld,
  output logic [DEPTH-1:0][4:0]  ent_rd
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the slots match.
  logic [AW:0]  r_wr_ptr, r_rd_ptr;
  lsu_entry_t   r_mem [DEPTH];
  logic [AW:0]  w_count;

  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign dout    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_count = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push && !full)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop && !empty)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [AW-1:0] w_off;
    assign w_off      = AW'(i) - r_rd_ptr[AW-1:0];
    assign ent_vld[i] = ({1'b0, w_off} < w_count);
    assign ent_rd[i]  = r_mem[i].rd;
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage driving the integer register-file write port.
// ALU results have priority; load returns are buffered in wb_lsu_fifo,
// extended on dequeue, and guaranteed service by a bounded starvation count.
// Ports:
//   clk, rst                          clock, async active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data/lsu_funct3/lsu_byte_off  load return
//   rd_addr/rd_wdata/rd_wen           registered register-file write port
//   pend_mask                         destinations of buffered loads (bit0=0)
// Optional (macro WB_PERF_EN): perf_wb_cnt, perf_starve_cnt counters.
module wb_stage
  import wb_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic [2:0]  lsu_funct3,
  input  logic [1:0]  lsu_byte_off,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  output logic [31:0] pend_mask
`ifdef WB_PERF_EN
  ,
  output logic [31:0] perf_wb_cnt,
  output logic [31:0] perf_starve_cnt
`endif
);

  localparam int SCW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  lsu_entry_t                        w_lsu_in, w_head;
  logic                              w_full, w_empty, w_push, w_pop;
  logic                              w_alu_win, w_starved;
  logic [LSU_FIFO_DEPTH-1:0]         w_ent_vld;
  logic [LSU_FIFO_DEPTH-1:0][4:0]    w_ent_rd;
  logic [SCW-1:0]                    r_starve_cnt;
  logic [4:0]                        r_rd_addr;
  logic [31:0]                       r_rd_wdata;
  logic                              r_rd_wen;

  assign w_lsu_in = '{rd: lsu_rd, data: lsu_data, funct3: lsu_funct3,
                      byte_off: lsu_byte_off};

  // No enqueue while full, even if the head leaves this same cycle.
  assign lsu_ready = !w_full && !rst;
  assign w_push    = lsu_valid && lsu_ready;

  assign w_starved = (r_starve_cnt == SCW'(STARVE_LIMIT)) && !w_empty;
  assign alu_ready = !w_starved;
  assign w_alu_win = alu_valid && alu_ready;
  assign w_pop     = !w_alu_win && !w_empty;

  wb_lsu_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .din     (w_lsu_in),
    .pop     (w_pop),
    .dout    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .ent_vld (w_ent_vld),
    .ent_rd  (w_ent_rd)
  );

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < LSU_FIFO_DEPTH; i++)
      if (w_ent_vld[i]) pend_mask[w_ent_rd[i]] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  // Counts consecutive ALU wins over a waiting load; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_starve_cnt <= '0;
    else if (w_empty || w_pop)
      r_starve_cnt <= '0;
    else if (w_alu_win && r_starve_cnt != SCW'(STARVE_LIMIT))
      r_starve_cnt <= r_starve_cnt + 1'b1;
  end

  // x0 writes still consume their source but never assert the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr  <= '0;
      r_rd_wdata <= '0;
      r_rd_wen   <= 1'b0;
    end else if (w_alu_win) begin
      r_rd_addr  <= alu_rd;
      r_rd_wdata <= alu_data;
      r_rd_wen   <= (alu_rd != 5'd0);
    end else if (w_pop) begin
      r_rd_addr  <= w_head.rd;
      r_rd_wdata <= load_extend(w_head);
      r_rd_wen   <= (w_head.rd != 5'd0);
    end else begin
      r_rd_wen   <= 1'b0;
    end
  end

  assign rd_addr  = r_rd_addr;
  assign rd_wdata = r_rd_wdata;
  assign rd_wen   = r_rd_wen;

`ifdef WB_PERF_EN
  logic [31:0] r_perf_wb, r_perf_starve;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_wb     <= '0;
      r_perf_starve <= '0;
    end else begin
      if (r_rd_wen)
        r_perf_wb <= r_perf_wb + 32'd1;
      if (alu_valid && !alu_ready)
        r_perf_starve <= r_perf_starve + 32'd1;
    end
  end

  assign perf_wb_cnt     = r_perf_wb;
  assign perf_starve_cnt = r_perf_starve;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage. Directed scenarios push the
// hand-computed register-file writes into a queue; a monitor compares every
// rd_wen pulse against the head of that queue.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic [2:0]  lsu_funct3 = '0;
  logic [1:0]  lsu_byte_off = '0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        rd_wen;
  logic [31:0] pend_mask;
`ifdef WB_PERF_EN
  logic [31:0] perf_wb_cnt, perf_starve_cnt;
  logic [31:0] wb0, st0;
`endif

  wb_stage #(.LSU_FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_funct3(lsu_funct3), .lsu_byte_off(lsu_byte_off),
    .rd_addr(rd_addr), .rd_wdata(rd_wdata), .rd_wen(rd_wen), .pend_mask(pend_mask)
`ifdef WB_PERF_EN
    , .perf_wb_cnt(perf_wb_cnt), .perf_starve_cnt(perf_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } exp_t;
  exp_t q[$];
  exp_t m_e;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle load return; rd==0 expects no write.
  task automatic lsu_push(input logic [4:0] rd, input logic [31:0] d,
                          input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] exp);
    if (rd != 5'd0) expect_wr(rd, exp);
    lsu_valid = 1'b1; lsu_rd = rd; lsu_data = d; lsu_funct3 = f3; lsu_byte_off = off;
    step();
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    chk(nm, 32'(q.size()), 32'd0);
    step();
    step();
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rd_wen) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", rd_addr, rd_wdata);
      end else begin
        m_e = q.pop_front();
        chk("wb_addr", 32'(rd_addr), 32'(m_e.a));
        chk("wb_data", rd_wdata, m_e.d);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_wen", 32'(rd_wen), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_wdata", rd_wdata, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);
    step();
    rst = 1'b0;
    step();

    // 1: ALU single-cycle latency, then x0 suppression
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    expect_wr(5'd5, 32'hDEADBEEF);
    step();
    alu_rd = 5'd0; alu_data = 32'h12345678;
    @(negedge clk);
    chk("t1_wen", 32'(rd_wen), 32'd1);
    chk("t1_addr", 32'(rd_addr), 32'd5);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("t1_rd0_wen", 32'(rd_wen), 32'd0);
    step();

    // 2: load extension, two-cycle latency
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0080FF00; lsu_funct3 = 3'b000; lsu_byte_off = 2'd2;
    expect_wr(5'd7, 32'hFFFFFF80);
    step();
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("t2_nobypass", 32'(rd_wen), 32'd0);
    step();
    @(negedge clk);
    chk("t2_lat2", 32'(rd_wen), 32'd1);
    step();
    lsu_push(5'd7,  32'h0080FF00, 3'b100, 2'd2, 32'h00000080);
    lsu_push(5'd7,  32'h0080FF00, 3'b001, 2'd2, 32'h00000080);
    lsu_push(5'd7,  32'h0080FF00, 3'b101, 2'd0, 32'h0000FF00);
    lsu_push(5'd8,  32'h80F01234, 3'b001, 2'd3, 32'hFFFF80F0);
    lsu_push(5'd9,  32'h80F01234, 3'b010, 2'd3, 32'h80F01234);
    lsu_push(5'd10, 32'h80F01234, 3'b011, 2'd1, 32'h80F01234);
    lsu_push(5'd11, 32'h80F01234, 3'b101, 2'd2, 32'h000080F0);
    lsu_push(5'd12, 32'h80F01234, 3'b000, 2'd0, 32'h00000034);
    lsu_push(5'd13, 32'h80F01234, 3'b000, 2'd3, 32'hFFFFFF80);
    lsu_push(5'd0,  32'h80F01234, 3'b010, 2'd0, 32'h0);
    lsu_push(5'd15, 32'h80F01234, 3'b111, 2'd0, 32'h80F01234);
    lsu_push(5'd14, 32'h80F01234, 3'b100, 2'd1, 32'h00000012);
    lsu_valid = 1'b0;
    drain("t2_drain");
    chk("t2_hold_addr", 32'(rd_addr), 32'd14);
    chk("t2_hold_data", rd_wdata, 32'h00000012);

    // 3: starvation with continuously valid ALU
`ifdef WB_PERF_EN
    wb0 = perf_wb_cnt; st0 = perf_starve_cnt;
`endif
    for (int c = 0; c < 17; c++) begin
      if (c % 4 == 0 && c > 0) expect_wr(5'(c / 4), 32'h11111111 * 32'(c / 4));
      else expect_wr(5'd20, 32'hA000 + 32'(c));
    end
    for (int c = 0; c < 17; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA000 + 32'(c);
      lsu_valid = (c < 4); lsu_rd = 5'(c + 1); lsu_data = 32'h11111111 * 32'(c + 1);
      lsu_funct3 = 3'b010; lsu_byte_off = 2'd0;
      @(negedge clk);
      chk("t3_alu_ready", 32'(alu_ready), (c % 4 == 0 && c > 0) ? 32'd0 : 32'd1);
      if (c == 4) begin
        chk("t3_full_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("t3_pend_full", pend_mask, 32'h0000001E);
      end
      if (c == 8) chk("t3_pend_3", pend_mask, 32'h0000001C);
      step();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    drain("t3_drain");
`ifdef WB_PERF_EN
    chk("t6_perf_starve", perf_starve_cnt - st0, 32'd4);
    chk("t6_perf_wb", perf_wb_cnt - wb0, 32'd17);
`endif

    // 4: full FIFO dequeues while a load is offered -> dropped
    expect_wr(5'd1, 32'hC0); expect_wr(5'd2, 32'hC1);
    expect_wr(5'd3, 32'hC2); expect_wr(5'd4, 32'hC3);
    for (int c = 0; c < 5; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'(c);
      lsu_valid = 1'b1; lsu_rd = (c < 4) ? 5'(c + 1) : 5'd9;
      lsu_data = 32'hC0 + 32'(c); lsu_funct3 = 3'b010; lsu_byte_off = 2'd0;
      @(negedge clk);
      if (c == 4) begin
        chk("t4_full_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("t4_starve_alu_ready", 32'(alu_ready), 32'd0);
      end
      step();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    chk("t4_ready_after", 32'(lsu_ready), 32'd1);
    drain("t4_drain");
    for (int k = 0; k < 10; k++)
      lsu_push(5'(11 + k), 32'h5A000000 + 32'(k), 3'b010, 2'd0, 32'h5A000000 + 32'(k));
    lsu_valid = 1'b0;
    drain("t4_wrap_drain");

    // 5: reset mid-drain
    for (int c = 0; c < 5; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'(c);
      lsu_valid = (c < 4); lsu_rd = 5'(21 + c); lsu_data = 32'hE0 + 32'(c);
      lsu_funct3 = 3'b010; lsu_byte_off = 2'd0;
      @(negedge clk);
      if (c == 4) chk("t5_pend_pre", pend_mask, 32'h01E00000);
      step();
    end
    rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    chk("t5_rst_wen", 32'(rd_wen), 32'd0);
    chk("t5_rst_wdata", rd_wdata, 32'd0);
    chk("t5_rst_pend", pend_mask, 32'd0);
    chk("t5_rst_lsu_ready", 32'(lsu_ready), 32'd0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("t5_post_pend", pend_mask, 32'd0);
    repeat (6) step();
    chk("t5_no_stale", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
